// File: rtl/trigger_round_scheduler.sv
// Round sequencer for a network of actor triggers: launches rounds,
// collects dones, and finishes after a run of quiet (no-fire) rounds.
module trigger_round_scheduler #(
    parameter int NUM_ACTORS   = 4,
    parameter int QUIET_ROUNDS = 2,
    parameter int WATCHDOG_W   = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [NUM_ACTORS-1:0] trig_start,
    input  logic [NUM_ACTORS-1:0] trig_done,
    input  logic [NUM_ACTORS-1:0] trig_sleeping,
    input  logic [NUM_ACTORS-1:0] trig_fired,
    output logic                  network_idle,
    output logic                  timed_out,
    output logic [31:0]           round_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [NUM_ACTORS-1:0] ALL_ONES = {NUM_ACTORS{1'b1}};
    localparam logic [WATCHDOG_W-1:0] WDOG_MAX = {WATCHDOG_W{1'b1}};
    localparam logic [3:0]            QUIET_LIM = 4'(QUIET_ROUNDS);

    state_t                  r_state;
    logic [NUM_ACTORS-1:0]   r_done_mask;
    logic                    r_fired_any;
    logic [3:0]              r_quiet;
    logic [WATCHDOG_W-1:0]   r_wdog;
    logic [31:0]             r_round_count;
    logic                    r_timed_out;

    state_t                  w_state_nxt;
    logic [NUM_ACTORS-1:0]   w_done_mask_nxt;
    logic                    w_fired_any_nxt;
    logic [3:0]              w_quiet_nxt;
    logic [3:0]              w_quiet_inc;
    logic [WATCHDOG_W-1:0]   w_wdog_nxt;
    logic [31:0]             w_round_count_nxt;
    logic                    w_timed_out_nxt;
    logic [NUM_ACTORS-1:0]   w_mask_upd;

    assign w_mask_upd  = r_done_mask | trig_done;
    assign w_quiet_inc = (r_quiet >= QUIET_LIM) ? QUIET_LIM : r_quiet + 4'd1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_done_mask   <= '0;
            r_fired_any   <= 1'b0;
            r_quiet       <= '0;
            r_wdog        <= '0;
            r_round_count <= '0;
            r_timed_out   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_done_mask   <= w_done_mask_nxt;
            r_fired_any   <= w_fired_any_nxt;
            r_quiet       <= w_quiet_nxt;
            r_wdog        <= w_wdog_nxt;
            r_round_count <= w_round_count_nxt;
            r_timed_out   <= w_timed_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_done_mask_nxt   = r_done_mask;
        w_fired_any_nxt   = r_fired_any;
        w_quiet_nxt       = r_quiet;
        w_wdog_nxt        = r_wdog;
        w_round_count_nxt = r_round_count;
        w_timed_out_nxt   = r_timed_out;
        trig_start        = '0;
        ap_done           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_nxt       = S_LAUNCH;
                    w_quiet_nxt       = '0;
                    w_round_count_nxt = '0;
                    w_timed_out_nxt   = 1'b0;
                end
            end
            S_LAUNCH: begin
                trig_start        = ALL_ONES;
                w_done_mask_nxt   = '0;
                w_fired_any_nxt   = 1'b0;
                w_wdog_nxt        = '0;
                w_round_count_nxt = r_round_count + 32'd1;
                w_state_nxt       = S_WAIT;
            end
            S_WAIT: begin
                w_done_mask_nxt = w_mask_upd;
                w_fired_any_nxt = r_fired_any | (|trig_fired);
                w_wdog_nxt      = r_wdog + 1'b1;
                // completion wins over a watchdog expiry in the same cycle
                if (w_mask_upd == ALL_ONES) begin
                    w_state_nxt = S_CHECK;
                end else if (r_wdog == WDOG_MAX) begin
                    w_timed_out_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end
            end
            S_CHECK: begin
                if (r_fired_any) begin
                    w_quiet_nxt = '0;
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_quiet_nxt = w_quiet_inc;
                    if (w_quiet_inc == QUIET_LIM) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // idle only when a prior round was quiet and nothing can still fire
    assign network_idle = (r_state == S_WAIT) & ~r_fired_any
                        & ~(|trig_fired)
                        & (&(r_done_mask | trig_sleeping))
                        & (r_quiet != 4'd0);

    assign ap_ready    = ap_done;
    assign ap_idle     = (r_state == S_IDLE);
    assign timed_out   = r_timed_out;
    assign round_count = r_round_count;

endmodule

// File: tb/tb_trigger_round_scheduler.sv
// Bench for trigger_round_scheduler: a round-level timeline model
// predicts every output per cycle; literal totals pin the model.
module tb_trigger_round_scheduler;

    localparam int NA   = 4;
    localparam int QR   = 2;
    localparam int WW   = 4;
    localparam int MAXC = 160;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_ready;
    logic          ap_idle;
    logic [NA-1:0] trig_start;
    logic [NA-1:0] trig_done;
    logic [NA-1:0] trig_sleeping;
    logic [NA-1:0] trig_fired;
    logic          network_idle;
    logic          timed_out;
    logic [31:0]   round_count;

    trigger_round_scheduler #(
        .NUM_ACTORS  (NA),
        .QUIET_ROUNDS(QR),
        .WATCHDOG_W  (WW)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready),
        .ap_idle      (ap_idle),
        .trig_start   (trig_start),
        .trig_done    (trig_done),
        .trig_sleeping(trig_sleeping),
        .trig_fired   (trig_fired),
        .network_idle (network_idle),
        .timed_out    (timed_out),
        .round_count  (round_count)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // per-test round description
    int         off[5][NA];
    int         fk[5];
    logic [3:0] fm[5];
    int         nr;
    bit         junk;
    logic [3:0] slp;

    // per-cycle model timeline
    logic [3:0] d_done[MAXC];
    logic [3:0] d_fire[MAXC];
    logic       x_start[MAXC];
    logic       x_done[MAXC];
    logic       x_idle[MAXC];
    logic       x_nidle[MAXC];
    int         t0;
    int         dc;
    int         t_end;
    int         n_start;
    int         n_done;
    int         n_nidle;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic build();
        int s;
        int q;
        int lng;
        int lim;
        bit never;
        bit nid;
        for (int i = 0; i < MAXC; i++) begin
            d_done[i]  = '0;
            d_fire[i]  = '0;
            x_start[i] = 1'b0;
            x_done[i]  = 1'b0;
            x_nidle[i] = 1'b0;
        end
        t0 = 2;
        s  = t0 + 1;
        q  = 0;
        dc = -1;
        for (int r = 0; r < nr; r++) begin
            x_start[s] = 1'b1;
            if (junk) begin
                d_done[s] = 4'hF;
                d_fire[s] = 4'hF;
            end
            lng   = 0;
            never = 1'b0;
            for (int b = 0; b < NA; b++) begin
                if (off[r][b] == 0) never = 1'b1;
                else if (off[r][b] > lng) lng = off[r][b];
            end
            lim = never ? (1 << WW) : lng;
            for (int k = 1; k <= lim; k++) begin
                for (int b = 0; b < NA; b++)
                    if (off[r][b] == k) d_done[s+k][b] = 1'b1;
                if (fk[r] == k) d_fire[s+k] = fm[r];
                nid = (q != 0) && !(fk[r] != 0 && fk[r] <= k);
                for (int b = 0; b < NA; b++)
                    if (!((off[r][b] != 0 && off[r][b] < k) || slp[b]))
                        nid = 1'b0;
                x_nidle[s+k] = nid;
            end
            if (never) begin
                dc = s + lim + 1;
                break;
            end
            q = (fk[r] != 0) ? 0 : q + 1;
            if (q == QR) begin
                dc = s + lng + 2;
                break;
            end
            s = s + lng + 2;
        end
        if (dc >= 0) x_done[dc] = 1'b1;
        for (int i = 0; i < MAXC; i++)
            x_idle[i] = (i <= t0) || (i > dc);
        t_end = dc + 3;
    endtask

    task automatic zero_inputs();
        ap_start      = 1'b0;
        trig_done     = '0;
        trig_fired    = '0;
        trig_sleeping = '0;
    endtask

    task automatic run(input int stop);
        n_start = 0;
        n_done  = 0;
        n_nidle = 0;
        for (int idx = 0; idx <= t_end; idx++) begin
            @(posedge ap_clk);
            #1;
            ap_start      = (idx == t0);
            trig_done     = d_done[idx];
            trig_fired    = d_fire[idx];
            trig_sleeping = slp;
            @(negedge ap_clk);
            chk("trig_start", trig_start, {NA{x_start[idx]}});
            chk("ap_done", ap_done, x_done[idx]);
            chk("ap_ready", ap_ready, x_done[idx]);
            chk("ap_idle", ap_idle, x_idle[idx]);
            chk("network_idle", network_idle, x_nidle[idx]);
            if (trig_start != '0) n_start++;
            if (ap_done) n_done++;
            if (network_idle) n_nidle++;
            if (idx == stop) return;
        end
        zero_inputs();
    endtask

    task automatic set_rounds(input int n, input int o0, input int o1,
                              input int o2, input int o3);
        nr = n;
        for (int r = 0; r < 5; r++) begin
            off[r][0] = o0;
            off[r][1] = o1;
            off[r][2] = o2;
            off[r][3] = o3;
            fk[r]     = 0;
            fm[r]     = '0;
        end
        junk = 1'b0;
        slp  = '0;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_done", ap_done, 1'b0);
        chk("rst_start", trig_start, 4'h0);
        chk("rst_nidle", network_idle, 1'b0);
        chk("rst_rc", round_count, 32'd0);
        chk("rst_to", timed_out, 1'b0);
        ap_rst_n = 1'b1;

        // T1: reset asserted while waiting for dones
        set_rounds(2, 3, 3, 3, 3);
        build();
        run(5);
        #2 ap_rst_n = 1'b0;
        zero_inputs();
        #1;
        chk("t1_idle", ap_idle, 1'b1);
        chk("t1_start", trig_start, 4'h0);
        chk("t1_done", ap_done, 1'b0);
        chk("t1_rc", round_count, 32'd0);
        repeat (3) begin
            @(negedge ap_clk);
            chk("t1_hold_done", ap_done, 1'b0);
        end
        ap_rst_n = 1'b1;

        // T2: two quiet rounds
        set_rounds(2, 3, 3, 3, 3);
        build();
        chk("t2_model_dc", dc, 13);
        run(-1);
        chk("t2_starts", n_start, 2);
        chk("t2_dones", n_done, 1);
        chk("t2_rc", round_count, 32'd2);
        chk("t2_to", timed_out, 1'b0);

        // T3: fire, quiet, fire (with same-cycle done), quiet, quiet
        set_rounds(5, 2, 2, 2, 2);
        fk[0] = 1;
        fm[0] = 4'b0001;
        fk[2] = 2;
        fm[2] = 4'b1000;
        build();
        chk("t3_model_dc", dc, 23);
        run(-1);
        chk("t3_starts", n_start, 5);
        chk("t3_rc", round_count, 32'd5);

        // T4: staggered dones, junk done/fire during launch ignored
        set_rounds(2, 1, 5, 5, 9);
        junk = 1'b1;
        build();
        chk("t4_model_dc", dc, 25);
        run(-1);
        chk("t4_starts", n_start, 2);
        chk("t4_rc", round_count, 32'd2);

        // T5: trigger 2 never reports done
        set_rounds(1, 2, 2, 0, 2);
        build();
        chk("t5_model_dc", dc, 20);
        run(-1);
        chk("t5_to", timed_out, 1'b1);
        chk("t5_rc", round_count, 32'd1);
        chk("t5_dones", n_done, 1);

        // T6: network_idle with a sleeping trigger, then killed by a fire
        set_rounds(4, 2, 2, 2, 2);
        off[0][0] = 3;
        off[0][1] = 3;
        off[0][2] = 3;
        off[0][3] = 3;
        off[1][0] = 1;
        off[1][1] = 1;
        off[1][2] = 2;
        off[1][3] = 6;
        fk[1] = 4;
        fm[1] = 4'b0010;
        slp   = 4'b1000;
        build();
        run(-1);
        chk("t6_nidle_cycles", n_nidle, 1);
        chk("t6_to_cleared", timed_out, 1'b0);
        chk("t6_rc", round_count, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
